adc128s022_ctrl: RTL and testbench

Hardware responder to the NIOS II ADC PIO interface on the DE0-Nano.
- Consumes the 4-bit command word from pio_adc_cmd.
- Runs SPI transactions to the on-board ADC128S022.
- Returns the 12-bit result and its channel number for pio_adc_data and pio_adc_channel.
- Sits in the top level between the NIOS_II_debug system and the ADC pins.

---
 rtl/adc128s022_pkg.sv | 32 +++
 rtl/adc128_spi_frame.sv | 98 +++++++++
 rtl/adc128s022_ctrl.sv | 149 ++++++++++++++
 tb/tb_adc128s022_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc128s022_pkg.sv
// Shared definitions for the ADC128S022 controller.
//   state_e     top-level sequencer states
//   FRAME_BITS  SCLK periods per SPI frame
//   LEAD_ZEROS  leading zero bits the ADC emits ahead of the result
//   DATA_W      conversion result width
//   ADD_MSB/LSB position of the channel address inside the control word
//   ctrl_word() builds the 16-bit DIN control word for a channel
package adc128s022_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCsSetup,
    StShift,
    StCsHold,
    StDone
  } state_e;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned LEAD_ZEROS = 4;
  localparam int unsigned DATA_W     = FRAME_BITS - LEAD_ZEROS;
  localparam int unsigned ADD_MSB    = 13;
  localparam int unsigned ADD_LSB    = 11;

  // Control word: 00, ADD[2:0], then eleven don't-care zeros.
  function automatic logic [FRAME_BITS-1:0] ctrl_word(input logic [2:0] chan);
    logic [FRAME_BITS-1:0] w;
    w                  = '0;
    w[ADD_MSB:ADD_LSB] = chan;
    return w;
  endfunction

endpackage

// File: rtl/adc128_spi_frame.sv
// Runs one 16-bit SPI frame to the ADC128S022 while chip select is held low by the parent.
// Each SCLK period is a low half followed by a high half, CLK_DIV clk cycles each.
// DIN changes on SCLK falling edges, DOUT is captured on SCLK rising edges.
//   clk_i    system clock
//   reset_i  asynchronous active-high reset
//   start_i  one-cycle pulse: begin a frame (first falling SCLK edge on the same clock edge)
//   chan_i   channel address placed in the control word
//   dout_i   ADC serial data
//   done_o   high in the last cycle of the frame (high half of bit 15 complete)
//   sclk_o   serial clock, idles high
//   din_o    serial control data, idles low
//   data_o   last DATA_W bits captured from DOUT
module adc128_spi_frame
  import adc128s022_pkg::*;
#(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [2:0]        chan_i,
  input  logic              dout_i,
  output logic              done_o,
  output logic              sclk_o,
  output logic              din_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int unsigned     CntW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] HalfLast = CntW'(CLK_DIV - 1);
  localparam logic [3:0]      BitLast  = 4'(FRAME_BITS - 1);

  logic [FRAME_BITS-1:0] ctrl_w;
  logic                  half_end;

  logic                  active_q;
  logic                  high_q;   // 0: low half of the period, 1: high half
  logic                  sclk_q;
  logic                  din_q;
  logic [CntW-1:0]       half_q;
  logic [3:0]            bit_q;    // index of the SCLK period in progress
  logic [FRAME_BITS-2:0] word_q;   // control bits still to be sent, next one at the MSB
  // Only the trailing DATA_W bits are kept; the leading zeros fall off the top.
  logic [DATA_W-1:0]     shift_q;

  assign ctrl_w   = ctrl_word(chan_i);
  assign half_end = (half_q == HalfLast);
  assign done_o   = active_q & high_q & half_end & (bit_q == BitLast);
  assign sclk_o   = sclk_q;
  assign din_o    = din_q;
  assign data_o   = shift_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      active_q <= 1'b0;
      high_q   <= 1'b0;
      sclk_q   <= 1'b1;
      din_q    <= 1'b0;
      half_q   <= '0;
      bit_q    <= '0;
      word_q   <= '0;
      shift_q  <= '0;
    end else if (!active_q) begin
      half_q <= '0;
      if (start_i) begin
        // Falling edge 0 happens together with the start pulse.
        active_q <= 1'b1;
        high_q   <= 1'b0;
        bit_q    <= '0;
        sclk_q   <= 1'b0;
        din_q    <= ctrl_w[FRAME_BITS-1];
        word_q   <= ctrl_w[FRAME_BITS-2:0];
        shift_q  <= '0;
      end
    end else if (!half_end) begin
      half_q <= half_q + CntW'(1);
    end else begin
      half_q <= '0;
      if (!high_q) begin
        // Rising edge: ADC drove DOUT on the previous falling edge.
        sclk_q  <= 1'b1;
        high_q  <= 1'b1;
        shift_q <= {shift_q[DATA_W-2:0], dout_i};
      end else if (bit_q == BitLast) begin
        active_q <= 1'b0;
        high_q   <= 1'b0;
        din_q    <= 1'b0;
      end else begin
        sclk_q <= 1'b0;
        high_q <= 1'b0;
        bit_q  <= bit_q + 4'd1;
        din_q  <= word_q[FRAME_BITS-2];
        word_q <= {word_q[FRAME_BITS-3:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/adc128s022_ctrl.sv
// NIOS PIO responder for the DE0-Nano ADC128S022.
// A rising edge on adc_cmd_i[3] starts a conversion of channel adc_cmd_i[2:0]. Two SPI frames
// are always run: the ADC converts the channel addressed in the previous frame, so frame 0
// programs the address and frame 1 returns its result. Frame-0 data is discarded.
//   clk_i          system clock (50 MHz)
//   reset_i        asynchronous active-high reset
//   adc_cmd_i      [3] start (rising edge), [2:0] channel
//   adc_data_o     last conversion result
//   adc_channel_o  channel of adc_data_o
//   adc_busy_o     conversion in progress
//   adc_valid_o    adc_data_o/adc_channel_o hold a fresh result
//   adc_cs_n_o     ADC chip select, active low
//   adc_sclk_o     ADC serial clock, idles high
//   adc_din_o      ADC control input
//   adc_dout_i     ADC serial data output
module adc128s022_ctrl
  import adc128s022_pkg::*;
#(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [3:0]        adc_cmd_i,
  output logic [DATA_W-1:0] adc_data_o,
  output logic [2:0]        adc_channel_o,
  output logic              adc_busy_o,
  output logic              adc_valid_o,
  output logic              adc_cs_n_o,
  output logic              adc_sclk_o,
  output logic              adc_din_o,
  input  logic              adc_dout_i
);

  localparam int unsigned     CntW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

  // PIO command is registered once, then start_q holds the previous start bit for edge detect.
  logic [3:0]        cmd_q;
  logic              start_q;
  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              frame_q;
  logic [2:0]        chan_q;
  logic [DATA_W-1:0] data_q;
  logic [2:0]        dch_q;
  logic              busy_q;
  logic              valid_q;
  logic              cs_n_q;

  logic              start_evt;
  logic              cnt_end;
  logic              frame_start;
  logic              frame_done;
  logic [DATA_W-1:0] frame_data;

  assign start_evt   = cmd_q[3] & ~start_q;
  assign cnt_end     = (cnt_q == CntLast);
  // The frame engine starts on the edge that ends CS setup, so SHIFT adds no extra cycle.
  assign frame_start = (state_q == StCsSetup) & cnt_end;

  adc128_spi_frame #(
    .CLK_DIV (CLK_DIV)
  ) u_frame (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .start_i (frame_start),
    .chan_i  (chan_q),
    .dout_i  (adc_dout_i),
    .done_o  (frame_done),
    .sclk_o  (adc_sclk_o),
    .din_o   (adc_din_o),
    .data_o  (frame_data)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cmd_q   <= '0;
      start_q <= 1'b0;
      state_q <= StIdle;
      cnt_q   <= '0;
      frame_q <= 1'b0;
      chan_q  <= '0;
      data_q  <= '0;
      dch_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      cs_n_q  <= 1'b1;
    end else begin
      cmd_q   <= adc_cmd_i;
      start_q <= cmd_q[3];
      case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (start_evt) begin
            chan_q  <= cmd_q[2:0];
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
            frame_q <= 1'b0;
            cs_n_q  <= 1'b0;
            state_q <= StCsSetup;
          end
        end
        StCsSetup: begin
          if (cnt_end) begin
            cnt_q   <= '0;
            state_q <= StShift;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StShift: begin
          if (frame_done) begin
            cs_n_q  <= 1'b1;
            state_q <= StCsHold;
          end
        end
        StCsHold: begin
          if (cnt_end) begin
            cnt_q <= '0;
            if (!frame_q) begin
              frame_q <= 1'b1;
              cs_n_q  <= 1'b0;
              state_q <= StCsSetup;
            end else begin
              busy_q  <= 1'b0;
              state_q <= StDone;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          data_q  <= frame_data;
          dch_q   <= chan_q;
          valid_q <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign adc_data_o    = data_q;
  assign adc_channel_o = dch_q;
  assign adc_busy_o    = busy_q;
  assign adc_valid_o   = valid_q;
  assign adc_cs_n_o    = cs_n_q;

endmodule

// File: tb/tb_adc128s022_ctrl.sv
// Bench for adc128s022_ctrl: one DUT at CLK_DIV=16 and one at CLK_DIV=2, each with an
// ADC128S022 behavioural model. Expected results are queued when a start is driven and
// compared when adc_valid rises.
module tb_adc128s022_ctrl;

  localparam int unsigned DivA = 16;
  localparam int unsigned DivB = 2;

  typedef struct {
    logic [2:0]  ch;
    logic [11:0] data;
    longint      t0;
    int          csf0;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0][3:0]  cmd_v = '0;
  logic [1:0][2:0]  exp_ch_v = '0;
  logic [1:0][11:0] data_v;
  logic [1:0][2:0]  chan_v;
  logic [1:0]       busy_v;
  logic [1:0]       valid_v;
  logic [1:0]       cs_n_v;
  logic [1:0]       sclk_v;
  logic [1:0]       din_v;
  longint           cyc = 0;
  int               n_checks = 0;
  int               n_pass = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [11:0] model_val(input logic [2:0] ch);
    case (ch)
      3'd0:    return 12'hFFF;
      3'd1:    return 12'h123;
      3'd2:    return 12'h2D3;
      3'd3:    return 12'h5A5;
      3'd4:    return 12'h444;
      3'd5:    return 12'hABC;
      3'd6:    return 12'h666;
      default: return 12'h001;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned Div = (g == 0) ? DivA : DivB;

    logic [11:0] data;
    logic [2:0]  chan;
    logic        busy, valid, cs_n, sclk, din;
    logic        dout = 1'b0;
    exp_t        sb_q[$];
    int          n_csf = 0;
    int          n_valid = 0;
    int          nbit = 0;
    int          nrise = 0;
    logic [15:0] word = '0;
    logic [15:0] ctrl = '0;
    logic [2:0]  prev_addr = '0;
    time         last_rise = 0;

    adc128s022_ctrl #(
      .CLK_DIV (Div)
    ) u_dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .adc_cmd_i     (cmd_v[g]),
      .adc_data_o    (data),
      .adc_channel_o (chan),
      .adc_busy_o    (busy),
      .adc_valid_o   (valid),
      .adc_cs_n_o    (cs_n),
      .adc_sclk_o    (sclk),
      .adc_din_o     (din),
      .adc_dout_i    (dout)
    );

    assign data_v[g]  = data;
    assign chan_v[g]  = chan;
    assign busy_v[g]  = busy;
    assign valid_v[g] = valid;
    assign cs_n_v[g]  = cs_n;
    assign sclk_v[g]  = sclk;
    assign din_v[g]   = din;

    // ADC model: converts the channel addressed in the previous complete frame.
    initial forever begin
      @(negedge cs_n);
      n_csf++;
      nbit  = 0;
      nrise = 0;
      ctrl  = '0;
      word  = {4'b0000, model_val(prev_addr)};
    end

    initial forever begin
      @(negedge sclk);
      if (cs_n === 1'b0 && nbit < 16) begin
        dout = word[15 - nbit];
        nbit++;
      end
    end

    initial forever begin
      @(posedge sclk);
      if (cs_n === 1'b0) begin
        ctrl = {ctrl[14:0], din};
        if (nrise > 0) check("sclk_period", 32'(($time - last_rise) / 20), 32'(2 * Div));
        last_rise = $time;
        nrise++;
      end
    end

    initial forever begin
      @(posedge cs_n);
      if (reset === 1'b0) begin
        check("frame_sclks", 32'(nrise), 32'd16);
        check("ctrl_word", 32'(ctrl), 32'({2'b00, exp_ch_v[g], 11'b0}));
        prev_addr = ctrl[13:11];
      end
    end

    // Result monitor: pops the scoreboard on each rising edge of valid.
    initial begin
      logic vp = 1'b0;
      exp_t e;
      forever begin
        @(posedge clk);
        #1;
        if (valid === 1'b1 && !vp) begin
          n_valid++;
          check("sb_pending", 32'(sb_q.size() > 0), 32'd1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("data", 32'(data), 32'(e.data));
            check("channel", 32'(chan), 32'(e.ch));
            check("latency", 32'(cyc - e.t0), 32'(68 * Div + 2));
            check("busy_at_valid", 32'(busy), 32'd0);
            check("frames", 32'(n_csf - e.csf0), 32'd2);
          end
        end
        vp = (valid === 1'b1);
      end
    end
  end

  function automatic int nvalid(input int d);
    return (d == 0) ? g_dut[0].n_valid : g_dut[1].n_valid;
  endfunction

  function automatic int ncsf(input int d);
    return (d == 0) ? g_dut[0].n_csf : g_dut[1].n_csf;
  endfunction

  // Drives a start at a falling clk edge, queues the expectation, checks acceptance timing.
  task automatic start_conv(input int d, input logic [2:0] ch);
    exp_t e;
    logic v_before;
    @(negedge clk);
    e.ch   = ch;
    e.data = model_val(ch);
    e.t0   = cyc + 1;
    e.csf0 = ncsf(d);
    if (d == 0) g_dut[0].sb_q.push_back(e);
    else        g_dut[1].sb_q.push_back(e);
    exp_ch_v[d] = ch;
    cmd_v[d]    = {1'b1, ch};
    v_before    = valid_v[d];
    @(posedge clk);
    #1;
    check("busy_at_t0", 32'(busy_v[d]), 32'd0);
    check("valid_at_t0", 32'(valid_v[d]), 32'(v_before));
    @(posedge clk);
    #1;
    check("busy_accept", 32'(busy_v[d]), 32'd1);
    check("valid_cleared", 32'(valid_v[d]), 32'd0);
  endtask

  task automatic wait_valid(input int d, input int n0, input int budget);
    for (int i = 0; i < budget && nvalid(d) == n0; i++) begin
      @(posedge clk);
      #2;
    end
    check("valid_seen", 32'(nvalid(d) - n0), 32'd1);
  endtask

  task automatic do_conv(input int d, input logic [2:0] ch, input int budget);
    int n0;
    n0 = nvalid(d);
    start_conv(d, ch);
    repeat (4) @(negedge clk);
    cmd_v[d][3] = 1'b0;
    wait_valid(d, n0, budget);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int bad;
    int n0;
    int c0;

    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Idle after reset
    check("rst_cs_n", 32'(cs_n_v), 32'h3);
    check("rst_sclk", 32'(sclk_v), 32'h3);
    check("rst_din", 32'(din_v), 32'h0);
    check("rst_busy", 32'(busy_v), 32'h0);
    check("rst_valid", 32'(valid_v), 32'h0);
    check("rst_data", 32'(data_v), 32'h0);
    check("rst_chan", 32'(chan_v), 32'h0);
    bad = 0;
    repeat (2000) begin
      @(posedge clk);
      #1;
      if ({cs_n_v, sclk_v, din_v, busy_v, valid_v} !== 10'b11_11_00_00_00 || data_v !== '0)
        bad++;
    end
    check("idle_hold", 32'(bad), 32'd0);

    // Single conversion, channel 5
    do_conv(0, 3'd5, 1300);

    // Start held high: exactly one conversion
    n0 = nvalid(0);
    start_conv(0, 3'd4);
    repeat (3000) @(negedge clk);
    check("held_one_conv", 32'(nvalid(0) - n0), 32'd1);
    cmd_v[0] = 4'b0000;

    // Extra start pulse with another channel while busy is ignored
    n0 = nvalid(0);
    start_conv(0, 3'd1);
    repeat (600) @(negedge clk);
    check("busy_mid", 32'(busy_v[0]), 32'd1);
    cmd_v[0] = 4'b0110;
    @(negedge clk);
    cmd_v[0] = 4'b1110;
    repeat (3) @(negedge clk);
    check("busy_after_pulse", 32'(busy_v[0]), 32'd1);
    cmd_v[0] = 4'b0000;
    wait_valid(0, n0, 1300);
    repeat (5) @(negedge clk);

    // Back-to-back extremes
    do_conv(0, 3'd0, 1300);
    do_conv(0, 3'd7, 1300);

    // Reset during frame 1 SHIFT, low half of bit 8
    c0 = ncsf(0);
    start_conv(0, 3'd6);
    repeat (4) @(negedge clk);
    cmd_v[0] = 4'b0000;
    for (int i = 0; i < 2000 && ncsf(0) - c0 < 2; i++) @(posedge clk);
    check("reach_frame1", 32'(ncsf(0) - c0), 32'd2);
    for (int i = 0; i < 2000 && g_dut[0].nbit < 9; i++) @(posedge clk);
    check("reach_bit8", 32'(g_dut[0].nbit), 32'd9);
    repeat (4) @(posedge clk);
    #5;
    check("pre_rst_sclk", 32'(sclk_v[0]), 32'd0);
    check("pre_rst_cs_n", 32'(cs_n_v[0]), 32'd0);
    reset = 1'b1;
    #1;
    check("async_cs_n", 32'(cs_n_v[0]), 32'd1);
    check("async_sclk", 32'(sclk_v[0]), 32'd1);
    check("async_din", 32'(din_v[0]), 32'd0);
    check("async_busy", 32'(busy_v[0]), 32'd0);
    check("async_valid", 32'(valid_v[0]), 32'd0);
    check("async_data", 32'(data_v[0]), 32'd0);
    g_dut[0].sb_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    do_conv(0, 3'd2, 1300);

    // Fast build: CLK_DIV = 2
    do_conv(1, 3'd3, 300);

    check("sb0_drained", 32'(g_dut[0].sb_q.size()), 32'd0);
    check("sb1_drained", 32'(g_dut[1].sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
